fetch_ctrl: RTL

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: PC sequencing, one-entry skid buffer, redirect and halt handling.
// Optional imem wait-cycle counter enabled by defining FETCH_WAIT_CNT_EN.
//
// state | meaning
// FETCH | requesting imem at pc, capturing into IF/ID when ready
// HOLD  | word parked in skid buffer while IF/ID is stalled
// REDIR | one cycle with no request after a taken branch
// HALT  | halt opcode fetched; frozen until reset
module fetch_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_addr,
    input  logic        imem_ready,
    input  logic [15:0] imem_instr,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    output logic [15:0] pc_out,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc2,
    output logic        ifid_valid,
    output logic        halted,
    output logic [15:0] wait_cnt
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        REDIR = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] pc, pc_nxt;
    logic [15:0] skid, skid_nxt;
    logic [15:0] ifid_instr_nxt, ifid_pc2_nxt;
    logic        ifid_valid_nxt;
    logic        capture;
    logic [15:0] cap_word;
    logic [15:0] pc_plus2;

    assign pc_plus2 = pc + 16'd2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FETCH;
            pc         <= 16'h0000;
            skid       <= 16'h0000;
            ifid_instr <= 16'h0000;
            ifid_pc2   <= 16'h0000;
            ifid_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            skid       <= skid_nxt;
            ifid_instr <= ifid_instr_nxt;
            ifid_pc2   <= ifid_pc2_nxt;
            ifid_valid <= ifid_valid_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        skid_nxt       = skid;
        ifid_instr_nxt = ifid_instr;
        ifid_pc2_nxt   = ifid_pc2;
        ifid_valid_nxt = ifid_valid;
        capture        = 1'b0;
        cap_word       = imem_instr;

        // Redirect beats stall, ready and a same-cycle halt capture.
        if (redirect && state != HALT) begin
            pc_nxt         = {redirect_addr[15:1], 1'b0};
            ifid_valid_nxt = 1'b0;
            skid_nxt       = 16'h0000;
            state_nxt      = REDIR;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ready) begin
                        if (stall) begin
                            skid_nxt  = imem_instr;
                            state_nxt = HOLD;
                        end else begin
                            capture = 1'b1;
                        end
                    end else if (!stall) begin
                        ifid_valid_nxt = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        capture  = 1'b1;
                        cap_word = skid;
                    end
                end
                REDIR:   state_nxt = FETCH;
                HALT:    state_nxt = HALT;
                default: state_nxt = FETCH;
            endcase
        end

        if (capture) begin
            ifid_instr_nxt = cap_word;
            ifid_pc2_nxt   = pc_plus2;
            ifid_valid_nxt = 1'b1;
            if (cap_word[15:12] == 4'hF) begin
                state_nxt = HALT;
            end else begin
                pc_nxt    = pc_plus2;
                state_nxt = FETCH;
            end
        end
    end

    assign imem_req  = (state == FETCH);
    assign imem_addr = pc;
    assign pc_out    = pc;
    assign halted    = (state == HALT);

`ifdef FETCH_WAIT_CNT_EN
    logic [15:0] wait_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= 16'h0000;
        end else if (state == FETCH && !imem_ready && wait_cnt_q != 16'hFFFF) begin
            wait_cnt_q <= wait_cnt_q + 16'd1;
        end
    end

    assign wait_cnt = wait_cnt_q;
`else
    assign wait_cnt = 16'h0000;
`endif

endmodule
